// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // True for a misaligned byte address or a word index beyond the memory.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned word_bits);
        return (addr[1:0] != 2'b00) || ((addr >> (word_bits + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: the pointer names the preferred requester.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Preferred requester wins if valid, otherwise the other one.
    always_comb begin
        grant = '0;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one combinational-read data memory,
// one transaction in flight at a time (IDLE -> ACCESS -> RESP).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WORDS = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0][31:0]  req_addr,
    input  logic [NUM_REQ-1:0][31:0]  req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      mem_we,
    output logic [31:0]               mem_a,
    output logic [31:0]               mem_wd,
    input  logic [31:0]               mem_rd
);

    localparam int unsigned WORD_BITS = $clog2(ADDR_WORDS);

    state_t               state;
    logic                 ptr;
    logic [NUM_REQ-1:0]   grant;
    logic                 win;
    logic                 gnt_q;
    logic                 we_q;
    logic                 err_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;

    rr_arbiter2 u_rr_arbiter2 (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign win = grant[1];

    // Grant is only offered in IDLE; gating with reset_n keeps it low during reset.
    assign req_ready = (state == IDLE && reset_n) ? grant : '0;

    // The registered request drives the memory port; it only changes on accept,
    // so the address and data hold their last values outside ACCESS.
    assign mem_a  = addr_q;
    assign mem_wd = wdata_q;
    assign mem_we = (state == ACCESS) && we_q && !err_q;

    // Transaction FSM: capture request, perform access, hold response until taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        gnt_q   <= win;
                        we_q    <= req_we[win];
                        addr_q  <= req_addr[win];
                        wdata_q <= req_wdata[win];
                        err_q   <= addr_error(req_addr[win], WORD_BITS);
                        ptr     <= ~win;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_rdata <= (we_q || err_q) ? '0 : mem_rd;
                    resp_err   <= err_q;
                    resp_valid <= gnt_q ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[gnt_q]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word memory.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [31:0]       mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    logic              load_en;
    logic [5:0]        load_addr;
    logic [31:0]       load_data;

    logic [31:0]       mem     [64];
    logic [31:0]       ref_mem [64];

    typedef struct {
        logic        idx;
        logic [31:0] rdata;
        logic        err;
        logic        we;
        logic [5:0]  word;
        logic [31:0] wdata;
    } exp_t;

    exp_t  sb[$];
    logic  grant_log[$];
    int    we_count = 0;
    logic [31:0] we_addr;
    logic [31:0] we_data;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_WORDS(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    function automatic logic [31:0] init_val(input int unsigned k);
        return (k == 5) ? 32'hDEADBEEF : 32'h1000_0000 + k * 7;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push at accept, compare at response handshake.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        if (load_en) ref_mem[load_addr] = load_data;
        if (!reset_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    a       = req_addr[i];
                    e.idx   = i[0];
                    e.we    = req_we[i];
                    e.word  = a[7:2];
                    e.wdata = req_wdata[i];
                    e.err   = (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
                    e.rdata = (e.err || e.we) ? 32'd0 : ref_mem[a[7:2]];
                    sb.push_back(e);
                    grant_log.push_back(i[0]);
                end
            end
            if (mem_we) begin
                we_count++;
                we_addr = mem_a;
                we_data = mem_wd;
            end
            if (resp_valid != 2'b00) check_eq("resp_onehot", {31'd0, $onehot(resp_valid)}, 32'd1);
            if ((resp_valid & resp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("resp_unexpected", {30'd0, resp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("resp_idx", {30'd0, resp_valid}, e.idx ? 32'd2 : 32'd1);
                    check_eq("resp_rdata", resp_rdata, e.rdata);
                    check_eq("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    if (e.we && !e.err) ref_mem[e.word] = e.wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid != 2'b00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("drain_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic wait_grants(input int base, input int cnt);
        int n;
        n = 0;
        while (grant_log.size() < base + cnt && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wb;
        reset_n    = 1'b0;
        req_valid  = 2'b11;
        req_we     = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        #1;
        check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_wd", mem_wd, 32'd0);
        req_valid = 2'b00;

        // Preload memory while reset is held.
        for (int unsigned k = 0; k < 64; k++) begin
            tick();
            load_en   = 1'b1;
            load_addr = k[5:0];
            load_data = init_val(k);
        end
        tick();
        load_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Single read of word 5 with latency checks.
        req_we[0] = 1'b0; req_addr[0] = 32'h14; req_valid = 2'b01;
        @(negedge clk);
        check_eq("rd_ready_T", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("rd_mem_we_T1", {31'd0, mem_we}, 32'd0);
        check_eq("rd_mem_a_T1", mem_a, 32'h14);
        check_eq("rd_no_resp_T1", {30'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check_eq("rd_resp_T2", {30'd0, resp_valid}, 32'd1);
        check_eq("rd_data_T2", resp_rdata, 32'hDEADBEEF);
        drain();

        // Write then read back by requester 1.
        wb = we_count;
        issue(1, 1'b1, 32'h20, 32'h12345678);
        drain();
        check_eq("wr_pulses", we_count - wb, 32'd1);
        check_eq("wr_addr", we_addr, 32'h20);
        check_eq("wr_data", we_data, 32'h12345678);
        check_eq("wr_mem8", mem[8], 32'h12345678);
        issue(1, 1'b0, 32'h20, 32'd0);
        drain();

        // Contention: both valid, grants must alternate starting at 0.
        base = grant_log.size();
        req_we = 2'b00;
        req_addr[0] = 32'h10;
        req_addr[1] = 32'h18;
        req_valid = 2'b11;
        wait_grants(base, 4);
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (grant_log.size() > base + k)
                check_eq("rr_order", {31'd0, grant_log[base + k]}, k % 2);
        end
        drain();

        // Error cases: misaligned and out-of-range writes.
        wb = we_count;
        issue(0, 1'b1, 32'h22, 32'hAAAA5555);
        drain();
        issue(0, 1'b1, 32'h100, 32'hBBBB6666);
        drain();
        check_eq("err_no_write", we_count - wb, 32'd0);
        check_eq("err_mem8", mem[8], 32'h12345678);
        check_eq("err_mem0", mem[0], init_val(0));

        // Backpressure on requester 0 with requester 1 waiting.
        resp_ready = 2'b10;
        base = grant_log.size();
        req_we[0] = 1'b0; req_addr[0] = 32'h14; req_valid[0] = 1'b1;
        wait_grants(base, 1);
        req_valid[0] = 1'b0;
        req_we[1] = 1'b0; req_addr[1] = 32'h18; req_valid[1] = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (resp_valid[0] !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check_eq("bp_resp_timeout", 32'd0, 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid", {30'd0, resp_valid}, 32'd1);
            check_eq("bp_rdata", resp_rdata, 32'hDEADBEEF);
            check_eq("bp_ready", {30'd0, req_ready}, 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_idle_ready", {30'd0, req_ready}, 32'd2);
        check_eq("bp_idle_valid", {30'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        // Reset during the ACCESS cycle of a write.
        issue(0, 1'b1, 32'h30, 32'hCAFEF00D);
        check_eq("rst_acc_we", {31'd0, mem_we}, 32'd1);
        check_eq("rst_acc_a", mem_a, 32'h30);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mid_a", mem_a, 32'd0);
        check_eq("rst_mid_wd", mem_wd, 32'd0);
        check_eq("rst_mid_resp", {30'd0, resp_valid}, 32'd0);
        req_we = 2'b00;
        req_addr[0] = 32'h30;
        req_addr[1] = 32'h14;
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("rst_mid_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        base = grant_log.size();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", {30'd0, req_ready}, 32'd1);
        check_eq("post_rst_resp", {30'd0, resp_valid}, 32'd0);
        check_eq("post_rst_mem12", mem[12], init_val(12));
        @(negedge clk);
        check_eq("post_rst_resp2", {30'd0, resp_valid}, 32'd0);
        wait_grants(base, 2);
        req_valid = 2'b00;
        if (grant_log.size() >= base + 2) begin
            check_eq("post_rst_first", {31'd0, grant_log[base]}, 32'd0);
            check_eq("post_rst_second", {31'd0, grant_log[base + 1]}, 32'd1);
        end
        drain();

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_WORDS, default 64, number of 32-bit words in the attached data memory (power of two).
REQ-002 Port: clk  input  1  rising-edge clock; the single clock domain.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-005 Port: req_ready  output  2  per-requester request accept.
REQ-006 Port: req_we  input  2  per-requester write (1) / read (0).
REQ-007 Port: req_addr  input  2x32  per-requester byte address.
REQ-008 Port: req_wdata  input  2x32  per-requester write data.
REQ-009 Port: resp_valid  output  2  per-requester response valid.
REQ-010 Port: resp_ready  input  2  per-requester response accept.
REQ-011 Port: resp_rdata  output  32  read data, shared; meaningful only where resp_valid is set.
REQ-012 Port: resp_err  output  1  error flag, shared; meaningful only where resp_valid is set.
REQ-013 Port: mem_we  output  1  write enable to the data memory.
REQ-014 Port: mem_a  output  32  byte address to the data memory.
REQ-015 Port: mem_wd  output  32  write data to the data memory.
REQ-016 Port: mem_rd  input  32  combinational read data from the data memory.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP; a single transaction is in flight at a time.
REQ-018 In IDLE, req_ready SHALL be one-hot to the winner among set req_valid bits, and zero when no request is valid.
REQ-019 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester; after a grant to i, the pointer becomes 1-i.
REQ-020 Handshake: a request is accepted when req_valid[i] & req_ready[i]; on acceptance we, addr, wdata and the grant index SHALL be registered, and the FSM SHALL go IDLE->ACCESS.
REQ-021 In ACCESS, mem_a and mem_wd SHALL come from the registered request.
REQ-022 In ACCESS, mem_we SHALL be 1 only for a registered write with no error.
REQ-023 In ACCESS, mem_rd SHALL be captured into resp_rdata, and the FSM SHALL go ACCESS->RESP.
REQ-024 In every state other than ACCESS, mem_we SHALL be 0; mem_a and mem_wd SHALL hold their last values.
REQ-025 Error condition: addr[1:0]!=0, or a word index >= ADDR_WORDS (addr[31:2+log2(ADDR_WORDS)] nonzero).
REQ-026 On error: no memory write, resp_err=1, resp_rdata=0.
REQ-027 For a write, resp_rdata SHALL be 0.
REQ-028 In RESP, resp_valid SHALL be set only for the granted requester and held with stable data until resp_ready for that requester; then the FSM SHALL go RESP->IDLE.
REQ-029 Latency: accept at cycle T, memory access in T+1, resp_valid from T+2; minimum 3 cycles between successive accepts.
REQ-030 Deasserting req_valid without acceptance SHALL have no effect.
REQ-031 resp_ready outside RESP, or for a non-granted requester, SHALL be ignored.

Reset
REQ-032 While reset_n=0, these SHALL be immediately and asynchronously 0: state=IDLE, pointer=0, req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd.
REQ-033 Reset asserted in ACCESS or RESP SHALL abort the transaction: no pending write completes, and no response is delivered after reset release.
REQ-034 The first cycle after reset release SHALL arbitrate normally, with requester 0 preferred.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCESS=1, RESP=2) and the requester-count constant 2.
REQ-036 One sub-module, rr_arbiter2 (combinational grant from valid bits plus pointer), SHALL be used; all else is flat.

Verification
REQ-037 Single read: memory word 5 = 32'hDEADBEEF; r0 reads addr 0x14 -> ready[0] at T, mem_we=0 at T+1, resp_valid[0] at T+2 with rdata 32'hDEADBEEF, err=0.
REQ-038 Write then read: r1 writes 0x20 with 32'h12345678, then reads 0x20 -> one-cycle mem_we=1 with mem_a=0x20; the read returns 32'h12345678.
REQ-039 Contention: both valid continuously, resp_ready=2'b11 -> grants alternate 0,1,0,1 across 4 transactions; no starvation.
REQ-040 Errors: r0 writes 0x22 (misaligned) and 0x100 (out of range) -> mem_we stays 0, resp_err=1, rdata=0, memory unchanged.
REQ-041 Backpressure: resp_ready[0]=0 for 5 cycles -> resp_valid[0] and rdata stable, no new accept, r1 ready stays 0; release -> IDLE next cycle.
REQ-042 Reset mid-operation: reset_n pulsed low during ACCESS of a write -> mem_we drops immediately, that write has no effect, no resp_valid after release, r0 wins first.
